clock_setup_ctrl: RTL and testbench

CLOCK_SETUP_CTRL -- requirements
Module: clock_setup_ctrl

---
 rtl/clock_pkg.sv | 30 +++
 rtl/key_repeat.sv | 48 ++++
 rtl/clock_setup_ctrl.sv | 142 ++++++++++++++
 tb/tb_clock_setup_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types for the clock setup controller: FSM state encoding, field codes
// and a counter-width helper that keeps tiny parameters from producing zero-width vectors.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    localparam logic [1:0] FIELD_HOUR = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_SEC  = 2'd2;
    localparam logic [1:0] FIELD_NONE = 2'd3;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            SET_HOUR: return FIELD_HOUR;
            SET_MIN:  return FIELD_MIN;
            SET_SEC:  return FIELD_SEC;
            default:  return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Rising-edge strobe for a held key with delayed auto-repeat. The strobe is a
// same-cycle decision; the parent registers it onto its increment outputs.
module key_repeat
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    input  logic cancel,
    output logic strobe
);

    localparam int RMAX = (REPEAT_DELAY - 1 > REPEAT_PERIOD) ? REPEAT_DELAY - 1 : REPEAT_PERIOD;
    localparam int RW   = cnt_w(RMAX + 1);
    localparam logic [RW-1:0] DLY_LOAD = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LOAD = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] ONE      = RW'(1);

    logic          lvl_d_reg;
    logic          active_reg;
    logic [RW-1:0] dly_reg;

    // A rising edge always implies a release, so a cancelled repeat needs no
    // separate lock-out: it simply stays inactive until the next edge.
    assign strobe = lvl && !cancel && (!lvl_d_reg || (active_reg && dly_reg == ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_d_reg  <= 1'b0;
            active_reg <= 1'b0;
            dly_reg    <= '0;
        end else begin
            lvl_d_reg <= lvl;
            if (cancel || !lvl) begin
                active_reg <= 1'b0;
            end else if (!lvl_d_reg) begin
                active_reg <= 1'b1;
                dly_reg    <= DLY_LOAD;
            end else if (active_reg) begin
                dly_reg <= (dly_reg == ONE) ? PER_LOAD : dly_reg - ONE;
            end
        end
    end

endmodule

// File: rtl/clock_setup_ctrl.sv
// Run/setup controller for a digital clock: 1 Hz prescaler, field selection,
// increment strobes with auto-repeat, blink of the selected field and idle timeout.
module clock_setup_ctrl
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int BLINK_HALF    = 12500000,
    parameter int TIMEOUT_CYC   = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_p,
    input  logic       next_p,
    input  logic       incr_lvl,
    output logic       sec_tick,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       inc_sec,
    output logic       setup,
    output logic [1:0] field,
    output logic       blink
);

    localparam int PW = cnt_w(TICKS_PER_SEC);
    localparam int BW = cnt_w(BLINK_HALF);
    localparam int IW = cnt_w(TIMEOUT_CYC);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_HALF - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [PW-1:0] presc_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          blink_ph_reg;
    logic [IW-1:0] idle_reg;
    logic          key_act;
    logic          cancel;
    logic          rep_strobe;
    logic [2:0]    inc_vec;

    assign key_act = mode_p || next_p || incr_lvl;

    always_comb begin
        state_next = state_reg;
        if (state_reg == RUN) begin
            if (mode_p) state_next = SET_HOUR;
        end else if (mode_p) begin
            state_next = RUN;
        end else if (next_p) begin
            case (state_reg)
                SET_HOUR: state_next = SET_MIN;
                SET_MIN:  state_next = SET_SEC;
                default:  state_next = SET_HOUR;
            endcase
        end else if (!incr_lvl && idle_reg == IDLE_LAST) begin
            state_next = RUN;
        end
    end

    // Any state change (field switch, exit, entry) kills a running repeat;
    // holding cancel through RUN makes a key held across entry need a re-press.
    assign cancel = (state_reg == RUN) || (state_next != state_reg);

    key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_key_repeat (
        .clk    (clk),
        .rst    (rst),
        .lvl    (incr_lvl),
        .cancel (cancel),
        .strobe (rep_strobe)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_inc
            logic inc_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) inc_q <= 1'b0;
                else     inc_q <= rep_strobe && (state_reg == state_t'(gi + 1));
            end
            assign inc_vec[gi] = inc_q;
        end
    endgenerate

    assign inc_hour = inc_vec[0];
    assign inc_min  = inc_vec[1];
    assign inc_sec  = inc_vec[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RUN;
            presc_reg     <= '0;
            sec_tick      <= 1'b0;
            setup         <= 1'b0;
            field         <= FIELD_NONE;
            blink_cnt_reg <= '0;
            blink_ph_reg  <= 1'b0;
            blink         <= 1'b0;
            idle_reg      <= '0;
        end else begin
            state_reg <= state_next;
            setup     <= (state_next != RUN);
            field     <= field_of(state_next);

            // Time only advances while staying in RUN, so re-entry restarts a full second.
            if (state_reg == RUN && state_next == RUN) begin
                if (presc_reg == PRE_LAST) begin
                    presc_reg <= '0;
                    sec_tick  <= 1'b1;
                end else begin
                    presc_reg <= presc_reg + PW'(1);
                    sec_tick  <= 1'b0;
                end
            end else begin
                presc_reg <= '0;
                sec_tick  <= 1'b0;
            end

            if (state_next == RUN || state_next != state_reg) begin
                blink_cnt_reg <= '0;
                blink_ph_reg  <= 1'b0;
                blink         <= 1'b0;
            end else if (blink_cnt_reg == BLK_LAST) begin
                blink_cnt_reg <= '0;
                blink_ph_reg  <= !blink_ph_reg;
                blink         <= !blink_ph_reg && !incr_lvl;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BW'(1);
                blink         <= blink_ph_reg && !incr_lvl;
            end

            if (state_reg == RUN || state_next != state_reg || key_act) idle_reg <= '0;
            else                                                       idle_reg <= idle_reg + IW'(1);
        end
    end

endmodule

// File: tb/tb_clock_setup_ctrl.sv
// Self-checking bench for clock_setup_ctrl with shortened timing parameters;
// every driven cycle queues its expectation, which is popped and compared after the edge.
module tb_clock_setup_ctrl;
    import clock_pkg::*;

    localparam int TPS = 10;
    localparam int RD  = 8;
    localparam int RP  = 3;
    localparam int BH  = 4;
    localparam int TO  = 50;

    localparam logic [7:0] M_ALL = 8'hFF;
    localparam logic [7:0] M_INC = 8'h70;
    localparam logic [7:0] M_SF  = 8'h0E;
    localparam logic [7:0] M_BLK = 8'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_p = 1'b0;
    logic       next_p = 1'b0;
    logic       incr_lvl = 1'b0;
    logic       sec_tick, inc_hour, inc_min, inc_sec, setup, blink;
    logic [1:0] field;
    logic [7:0] obs;

    always #5 clk = ~clk;

    clock_setup_ctrl #(
        .TICKS_PER_SEC (TPS),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .BLINK_HALF    (BH),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode_p   (mode_p),
        .next_p   (next_p),
        .incr_lvl (incr_lvl),
        .sec_tick (sec_tick),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .inc_sec  (inc_sec),
        .setup    (setup),
        .field    (field),
        .blink    (blink)
    );

    assign obs = {sec_tick, inc_hour, inc_min, inc_sec, setup, field, blink};

    typedef struct {
        string      name;
        logic [7:0] exp;
        logic [7:0] mask;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit         m;
        bit         n;
        bit         i;
        bit         exp_setup;
        logic [1:0] exp_field;
        logic [2:0] exp_inc;
    } vec_t;
    vec_t tbl[9];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] mk(bit t, bit ih, bit im, bit is, bit s, logic [1:0] f, bit b);
        return {t, ih, im, is, s, f, b};
    endfunction

    task automatic cmp(input string name, input logic [7:0] exp, input logic [7:0] mask);
        n_checks++;
        if ((obs & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (mask %b) at %0t", name, obs, exp, mask, $time);
        end else begin
            $display("check %s ok: %b", name, obs & mask);
        end
    endtask

    task automatic pop_cmp();
        sb_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue want entry");
        end else begin
            e = sb_q.pop_front();
            cmp(e.name, e.exp, e.mask);
        end
    endtask

    // Drive one cycle of inputs, then check the outputs registered at that edge.
    task automatic step(input string name, input bit m, input bit n, input bit i,
                        input logic [7:0] exp, input logic [7:0] mask);
        mode_p   = m;
        next_p   = n;
        incr_lvl = i;
        sb_q.push_back('{name, exp, mask});
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    task automatic now_check(input string name, input logic [7:0] exp, input logic [7:0] mask);
        sb_q.push_back('{name, exp, mask});
        pop_cmp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, FIELD_HOUR, 3'b000};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, FIELD_HOUR, 3'b000};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, FIELD_MIN,  3'b000};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, FIELD_SEC,  3'b000};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, FIELD_HOUR, 3'b000};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, FIELD_MIN,  3'b000};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, FIELD_NONE, 3'b000};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, FIELD_NONE, 3'b000};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, FIELD_NONE, 3'b000};

        // Reset state, then free-running seconds
        @(posedge clk);
        @(posedge clk);
        #1;
        now_check("reset", mk(0, 0, 0, 0, 0, FIELD_NONE, 0), M_ALL);
        rst = 1'b0;
        for (int n = 1; n <= 35; n++)
            step($sformatf("run_tick[%0d]", n), 0, 0, 0,
                 mk(n % TPS == 0, 0, 0, 0, 0, FIELD_NONE, 0), M_ALL);

        // Mode/next navigation table
        for (int v = 0; v < 9; v++)
            step($sformatf("nav_tbl[%0d]", v), tbl[v].m, tbl[v].n, tbl[v].i,
                 mk(0, tbl[v].exp_inc[2], tbl[v].exp_inc[1], tbl[v].exp_inc[0],
                    tbl[v].exp_setup, tbl[v].exp_field, 0), M_INC | M_SF);

        // Short press in SET_MIN gives exactly one inc_min
        step("min_enter", 1, 0, 0, mk(0, 0, 0, 0, 1, FIELD_HOUR, 0), M_SF);
        step("min_next",  0, 1, 0, mk(0, 0, 0, 0, 1, FIELD_MIN, 0),  M_SF);
        step("min_press0", 0, 0, 1, mk(0, 0, 1, 0, 1, FIELD_MIN, 0), M_INC | M_SF);
        step("min_press1", 0, 0, 1, mk(0, 0, 0, 0, 1, FIELD_MIN, 0), M_INC | M_SF);
        for (int k = 0; k < 10; k++)
            step($sformatf("min_idle[%0d]", k), 0, 0, 0, mk(0, 0, 0, 0, 1, FIELD_MIN, 0), M_INC | M_SF);
        step("min_exit", 1, 0, 0, mk(0, 0, 0, 0, 0, FIELD_NONE, 0), M_INC | M_SF);

        // Auto-repeat in SET_SEC; released exactly at the +20 repeat slot
        step("sec_enter", 1, 0, 0, mk(0, 0, 0, 0, 1, FIELD_HOUR, 0), M_SF);
        step("sec_next1", 0, 1, 0, mk(0, 0, 0, 0, 1, FIELD_MIN, 0),  M_SF);
        step("sec_next2", 0, 1, 0, mk(0, 0, 0, 0, 1, FIELD_SEC, 0),  M_SF);
        for (int k = 0; k < 19; k++)
            step($sformatf("sec_hold[+%0d]", k + 1), 0, 0, 1,
                 mk(0, 0, 0, (k == 0 || k == 7 || k == 10 || k == 13 || k == 16), 1, FIELD_SEC, 0),
                 M_INC | M_SF | M_BLK);
        for (int k = 19; k < 31; k++)
            step($sformatf("sec_rel[+%0d]", k + 1), 0, 0, 0, mk(0, 0, 0, 0, 1, FIELD_SEC, 0), M_INC | M_SF);
        step("sec_exit", 1, 0, 0, mk(0, 0, 0, 0, 0, FIELD_NONE, 0), M_INC | M_SF);

        // Key held from RUN into setup: no strobe until re-press
        for (int k = 0; k < 3; k++)
            step($sformatf("run_hold[%0d]", k), 0, 0, 1, mk(0, 0, 0, 0, 0, FIELD_NONE, 0), M_INC | M_SF);
        step("hold_enter", 1, 0, 1, mk(0, 0, 0, 0, 1, FIELD_HOUR, 0), M_INC | M_SF);
        for (int k = 0; k < 10; k++)
            step($sformatf("hold_set[%0d]", k), 0, 0, 1, mk(0, 0, 0, 0, 1, FIELD_HOUR, 0), M_INC | M_SF);
        step("hold_rel", 0, 0, 0, mk(0, 0, 0, 0, 1, FIELD_HOUR, 0), M_INC | M_SF);
        step("hour_press", 0, 0, 1, mk(0, 1, 0, 0, 1, FIELD_HOUR, 0), M_INC | M_SF);
        for (int k = 0; k < 3; k++)
            step($sformatf("hour_hold[%0d]", k), 0, 0, 1, mk(0, 0, 0, 0, 1, FIELD_HOUR, 0), M_INC | M_SF);

        // Field change while held cancels the repeat
        step("cancel_next", 0, 1, 1, mk(0, 0, 0, 0, 1, FIELD_MIN, 0), M_INC | M_SF);
        for (int k = 0; k < 12; k++)
            step($sformatf("cancel_hold[%0d]", k), 0, 0, 1, mk(0, 0, 0, 0, 1, FIELD_MIN, 0), M_INC | M_SF);
        step("cancel_rel", 0, 0, 0, mk(0, 0, 0, 0, 1, FIELD_MIN, 0), M_INC | M_SF);
        step("cancel_repress", 0, 0, 1, mk(0, 0, 1, 0, 1, FIELD_MIN, 0), M_INC | M_SF);
        step("cancel_rel2", 0, 0, 0, mk(0, 0, 0, 0, 1, FIELD_MIN, 0), M_INC | M_SF);
        step("cancel_exit", 1, 0, 0, mk(0, 0, 0, 0, 0, FIELD_NONE, 0), M_INC | M_SF);

        // Idle timeout with blink, then a full second before the first tick
        for (int k = 0; k <= 60; k++) begin
            if (k < TO)
                step($sformatf("timeout[%0d]", k), k == 0, 0, 0,
                     mk(0, 0, 0, 0, 1, FIELD_HOUR, ((k / BH) % 2) == 1), M_ALL);
            else
                step($sformatf("timeout[%0d]", k), 0, 0, 0,
                     mk(k == TO + TPS, 0, 0, 0, 0, FIELD_NONE, 0), M_ALL);
        end

        // Reset in the middle of an auto-repeat in SET_MIN
        step("rr_enter", 1, 0, 0, mk(0, 0, 0, 0, 1, FIELD_HOUR, 0), M_SF);
        step("rr_next",  0, 1, 0, mk(0, 0, 0, 0, 1, FIELD_MIN, 0),  M_SF);
        for (int k = 0; k < 11; k++)
            step($sformatf("rr_hold[+%0d]", k + 1), 0, 0, 1,
                 mk(0, 0, (k == 0 || k == 7 || k == 10), 0, 1, FIELD_MIN, 0), M_INC | M_SF);
        #2;
        rst = 1'b1;
        #1;
        now_check("rr_rst_now", mk(0, 0, 0, 0, 0, FIELD_NONE, 0), M_ALL);
        @(posedge clk);
        #1;
        now_check("rr_rst_held", mk(0, 0, 0, 0, 0, FIELD_NONE, 0), M_ALL);
        rst = 1'b0;
        for (int n = 1; n <= 12; n++)
            step($sformatf("rr_run[%0d]", n), 0, 0, 1,
                 mk(n == TPS, 0, 0, 0, 0, FIELD_NONE, 0), M_ALL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
